// File: rtl/morty_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC hold/select plus stall/flush for the
// IF/ID, ID/EX, EX/MEM and MEM/WB stage registers (load-use, memory wait, redirects, fence drain).
module morty_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int TRAP_HOLD    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_waddr,
  input  logic       i_ex_we,
  input  logic       i_ex_is_load,
  input  logic       i_ex_branch_taken,
  input  logic       i_ex_xret_op,
  input  logic       i_ex_fence_op,
  input  logic       i_mem_trap_valid,
  input  logic       i_imem_stall,
  input  logic       i_dmem_stall,
  output logic       o_pc_stall,
  output logic [1:0] o_pc_sel,
  output logic       o_ifid_stall,
  output logic       o_ifid_flush,
  output logic       o_idex_stall,
  output logic       o_idex_flush,
  output logic       o_exmem_stall,
  output logic       o_exmem_flush,
  output logic       o_memwb_flush,
  output logic       o_fence_busy
);

  localparam int MAX_CNT = (DRAIN_CYCLES > TRAP_HOLD) ? DRAIN_CYCLES : TRAP_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_FENCE = 2'b01;
  localparam logic [1:0] S_TRAP  = 2'b10;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;
  localparam logic [1:0] SEL_XEPC = 2'b11;

  logic [1:0]    r_fsm;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_fsm_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic       w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
  logic       w_exmem_stall, w_exmem_flush, w_memwb_flush, w_fence_busy;
  logic [1:0] w_pc_sel;
  logic       w_load_use;

  assign w_load_use = i_ex_is_load && i_ex_we && (i_ex_waddr != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_waddr)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_waddr)));

  always_comb begin
    w_pc_stall    = 1'b0;
    w_pc_sel      = SEL_SEQ;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_stall = 1'b0;
    w_exmem_flush = 1'b0;
    w_memwb_flush = 1'b0;
    w_fence_busy  = 1'b0;
    w_fsm_nxt     = r_fsm;
    w_cnt_nxt     = r_cnt;

    if (i_rst) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_memwb_flush = 1'b1;
      w_fsm_nxt     = S_RUN;
      w_cnt_nxt     = '0;
    end else if (i_mem_trap_valid) begin
      // A committed trap pre-empts everything, including an in-flight fence.
      w_pc_sel      = SEL_TRAP;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_memwb_flush = 1'b1;
      w_fsm_nxt     = S_TRAP;
      w_cnt_nxt     = CW'(TRAP_HOLD - 1);
    end else begin
      case (r_fsm)
        S_RUN: begin
          if (i_dmem_stall) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
          end else if (i_ex_xret_op) begin
            w_pc_sel     = SEL_XEPC;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (i_ex_branch_taken) begin
            w_pc_sel     = SEL_BR;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (i_ex_fence_op) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
            w_fence_busy = 1'b1;
            w_fsm_nxt    = S_FENCE;
            w_cnt_nxt    = CW'(DRAIN_CYCLES);
          end else if (w_load_use) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
          end else if (i_imem_stall) begin
            w_pc_stall   = 1'b1;
            w_ifid_flush = 1'b1;
          end
        end
        S_FENCE: begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_flush = 1'b1;
          w_fence_busy = 1'b1;
          if (i_dmem_stall) begin
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_fsm_nxt = S_RUN;
          end
        end
        S_TRAP: begin
          w_ifid_flush = 1'b1;
          if (r_cnt == '0) w_fsm_nxt = S_RUN;
          else             w_cnt_nxt = r_cnt - CW'(1);
        end
        default: begin
          w_fsm_nxt = S_RUN;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_fsm <= w_fsm_nxt;
    r_cnt <= w_cnt_nxt;
  end

  // Flush beats stall on the same register; the ID/EX bubble is the NOP 32'h33.
  assign o_pc_stall    = w_pc_stall;
  assign o_pc_sel      = w_pc_sel;
  assign o_ifid_stall  = w_ifid_stall  & ~w_ifid_flush;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_stall  = w_idex_stall  & ~w_idex_flush;
  assign o_idex_flush  = w_idex_flush;
  assign o_exmem_stall = w_exmem_stall & ~w_exmem_flush;
  assign o_exmem_flush = w_exmem_flush;
  assign o_memwb_flush = w_memwb_flush;
  assign o_fence_busy  = w_fence_busy;

endmodule

// File: tb/tb_morty_hazard_ctrl.sv
// Bench for morty_hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_morty_hazard_ctrl;
  localparam int DRAIN = 2;
  localparam int THOLD = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_waddr;
  logic       id_use_rs1, id_use_rs2, ex_we, ex_is_load, ex_branch_taken, ex_xret_op;
  logic       ex_fence_op, mem_trap_valid, imem_stall, dmem_stall;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, exmem_flush, memwb_flush, fence_busy;
  logic [1:0] pc_sel;

  int n_chk  = 0;
  int n_pass = 0;
  logic obs_fb;

  // Model: mode 0 = running, 1 = fence draining, 2 = post-trap hold; left = cycles remaining.
  int m_mode = 0;
  int m_left = 0;

  always #5 clk = ~clk;

  morty_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .TRAP_HOLD(THOLD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_waddr(ex_waddr), .i_ex_we(ex_we), .i_ex_is_load(ex_is_load),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_xret_op(ex_xret_op), .i_ex_fence_op(ex_fence_op),
    .i_mem_trap_valid(mem_trap_valid), .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall),
    .o_pc_stall(pc_stall), .o_pc_sel(pc_sel), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
    .o_idex_stall(idex_stall), .o_idex_flush(idex_flush), .o_exmem_stall(exmem_stall),
    .o_exmem_flush(exmem_flush), .o_memwb_flush(memwb_flush), .o_fence_busy(fence_busy)
  );

  wire [10:0] obs = {pc_stall, pc_sel, ifid_stall, ifid_flush, idex_stall, idex_flush,
                     exmem_stall, exmem_flush, memwb_flush, fence_busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic idle();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_waddr = 0;
    ex_we = 0; ex_is_load = 0; ex_branch_taken = 0; ex_xret_op = 0; ex_fence_op = 0;
    mem_trap_valid = 0; imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic model(output logic [10:0] e, output int nm, output int nl);
    logic ps, fs, ff, ds, df, es, ef, wf, fb, hazard;
    logic [1:0] sel;
    ps = 0; fs = 0; ff = 0; ds = 0; df = 0; es = 0; ef = 0; wf = 0; fb = 0; sel = 2'd0;
    nm = m_mode; nl = m_left;
    hazard = ex_is_load && ex_we && (ex_waddr != 0) &&
             ((id_use_rs1 && id_rs1 == ex_waddr) || (id_use_rs2 && id_rs2 == ex_waddr));
    if (rst) begin
      ff = 1; df = 1; ef = 1; wf = 1; nm = 0; nl = 0;
    end else if (mem_trap_valid) begin
      sel = 2'd2; ff = 1; df = 1; ef = 1; wf = 1; nm = 2; nl = THOLD - 1;
    end else if (m_mode == 1) begin
      ps = 1; fs = 1; df = 1; fb = 1;
      if (dmem_stall) begin es = 1; wf = 1; end
      else if (m_left > 0) nl = m_left - 1;
      else nm = 0;
    end else if (m_mode == 2) begin
      ff = 1;
      if (m_left == 0) nm = 0; else nl = m_left - 1;
    end else if (dmem_stall) begin
      ps = 1; fs = 1; ds = 1; es = 1; wf = 1;
    end else if (ex_xret_op) begin
      sel = 2'd3; ff = 1; df = 1;
    end else if (ex_branch_taken) begin
      sel = 2'd1; ff = 1; df = 1;
    end else if (ex_fence_op) begin
      ps = 1; fs = 1; df = 1; fb = 1; nm = 1; nl = DRAIN;
    end else if (hazard) begin
      ps = 1; fs = 1; df = 1;
    end else if (imem_stall) begin
      ps = 1; ff = 1;
    end
    e = {ps, sel, fs & ~ff, ff, ds & ~df, df, es & ~ef, ef, wf, fb};
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick(input string tag);
    logic [10:0] e;
    int nm, nl;
    #1;
    model(e, nm, nl);
    obs_fb = fence_busy;
    chk(tag, 32'(obs), 32'(e));
    @(posedge clk);
    m_mode = nm; m_left = nl;
    @(negedge clk);
  endtask

  initial begin
    int fb_cnt;
    idle();
    @(negedge clk);

    // T1 reset
    rst = 1; tick("rst0"); tick("rst1");
    rst = 0; tick("post_rst");
    chk("post_rst_zero", 32'(obs_fb), 32'd0);

    // T2 load-use and x0 exemption
    ex_is_load = 1; ex_we = 1; ex_waddr = 5; id_rs2 = 5; id_use_rs2 = 1;
    tick("load_use");
    ex_waddr = 0; id_rs2 = 0; tick("load_use_x0");

    // T3 branch outranks load-use
    ex_waddr = 5; id_rs2 = 5; ex_branch_taken = 1; tick("branch_over_lu");
    idle(); tick("idle0");

    // T4 fence with memory wait mid-drain
    fb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ex_fence_op = (i == 0);
      dmem_stall  = (i == 2);
      tick("fence_seq");
      fb_cnt += int'(obs_fb);
    end
    chk("fence_busy_len", 32'(fb_cnt), 32'd5);
    idle();

    // T5 trap outranks data-memory wait
    dmem_stall = 1; mem_trap_valid = 1; tick("trap_dmem");
    idle(); tick("trap_hold"); tick("trap_back_run");

    // T6 reset during fence
    ex_fence_op = 1; tick("fence_enter");
    ex_fence_op = 0; rst = 1; tick("rst_in_fence");
    rst = 0; tick("after_rst_fence");
    chk("after_rst_fence_busy", 32'(obs_fb), 32'd0);

    // other redirect / stall rules
    ex_xret_op = 1; ex_branch_taken = 1; tick("xret_over_branch");
    idle(); imem_stall = 1; tick("imem_stall");
    idle(); dmem_stall = 1; ex_xret_op = 1; tick("dmem_over_xret");
    idle(); tick("idle1");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(63) == 0);
      mem_trap_valid  = ($urandom_range(15) == 0);
      dmem_stall      = ($urandom_range(5) == 0);
      ex_xret_op      = ($urandom_range(15) == 0);
      ex_branch_taken = ($urandom_range(7) == 0);
      ex_fence_op     = ($urandom_range(9) == 0);
      imem_stall      = ($urandom_range(5) == 0);
      ex_is_load      = 1'($urandom_range(1));
      ex_we           = 1'($urandom_range(1));
      ex_waddr        = 5'($urandom_range(3));
      id_rs1          = 5'($urandom_range(3));
      id_rs2          = 5'($urandom_range(3));
      id_use_rs1      = 1'($urandom_range(1));
      id_use_rs2      = 1'($urandom_range(1));
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
